// File: rtl/bitmap_allocator.sv
// bitmap_allocator: ownership bitmap for LIST_SIZE slots. It provides an
// allocate-lowest-free port, a claim-specific port, FREE_PORTS independent free
// ports, per-port error pulses and registered occupancy flags. Every request in a
// cycle is resolved against the bitmap as it stood before the clock edge, so a
// slot released this cycle only becomes available to claim/allocate next cycle.
module bitmap_allocator #(
    parameter int LIST_SIZE  = 32,
    parameter int FREE_PORTS = 2,
    parameter int LOW_WATER  = 4,
    localparam int IW = $clog2(LIST_SIZE),
    localparam int CW = $clog2(LIST_SIZE + 1)
) (
    input  logic                     CLK,
    input  logic                     RSTN,
    input  logic                     ALLOC_REQ,
    output logic                     ALLOC_GNT,
    output logic                     ALLOC_FAIL,
    output logic [IW-1:0]            ALLOC_IDX,
    input  logic                     CLAIM_EN,
    input  logic [IW-1:0]            CLAIM_IDX,
    output logic                     CLAIM_ERR,
    input  logic [FREE_PORTS-1:0]    FREE_EN,
    input  logic [FREE_PORTS*IW-1:0] FREE_IDX,
    output logic [FREE_PORTS-1:0]    FREE_ERR,
    output logic [CW-1:0]            FREE_COUNT,
    output logic                     EMPTY,
    output logic                     LOW,
    output logic                     ALL_FREE
);

    // Slot count as an index-width+1 quantity, so out-of-range indices compare
    // correctly when LIST_SIZE is not a power of two.
    localparam logic [IW:0] SLOTS_W   = (IW + 1)'(LIST_SIZE);
    localparam logic [CW:0] FULL_CNT  = (CW + 1)'(LIST_SIZE);
    localparam logic        RESET_LOW = (LIST_SIZE <= LOW_WATER);

    // True when an index addresses a real slot.
    function automatic logic idx_in_range(input logic [IW-1:0] idx);
        return ({1'b0, idx} < SLOTS_W);
    endfunction

    // Lowest set bit of the mask; the MSB of the result flags that one was found.
    function automatic logic [IW:0] lowest_set(input logic [LIST_SIZE-1:0] mask);
        logic [IW:0] hit;
        hit = {(IW + 1){1'b0}};
        for (int i = LIST_SIZE - 1; i >= 0; i--) begin
            hit = mask[i] ? {1'b1, IW'(i)} : hit;
        end
        return hit;
    endfunction

    // State and registered responses
    logic [LIST_SIZE-1:0]  list_r;
    logic [CW-1:0]         count_r;
    logic                  alloc_gnt_r;
    logic                  alloc_fail_r;
    logic [IW-1:0]         alloc_idx_r;
    logic                  claim_err_r;
    logic [FREE_PORTS-1:0] free_err_r;
    logic                  empty_r;
    logic                  low_r;
    logic                  all_free_r;

    // Per-cycle decisions
    logic                  claim_hit_s;
    logic                  claim_ok_s;
    logic                  claim_err_s;
    logic [LIST_SIZE-1:0]  search_s;
    logic [IW:0]           pick_s;
    logic                  alloc_ok_s;
    logic                  alloc_fail_s;
    logic [FREE_PORTS-1:0] free_ok_s;
    logic [FREE_PORTS-1:0] free_err_s;
    logic [LIST_SIZE-1:0]  list_next_s;
    logic [CW:0]           free_num_s;
    logic [CW:0]           count_next_s;
    logic                  empty_next_s;
    logic                  low_next_s;
    logic                  all_free_next_s;

    // Resolve the claim, then pick the lowest free slot the claim is not taking
    always_comb begin
        claim_hit_s = CLAIM_EN && idx_in_range(CLAIM_IDX);
        claim_ok_s  = claim_hit_s && !list_r[CLAIM_IDX];
        claim_err_s = CLAIM_EN && !claim_ok_s;
        search_s    = ~list_r;
        if (claim_hit_s) begin
            search_s[CLAIM_IDX] = 1'b0;
        end else begin
            search_s = ~list_r;
        end
        pick_s       = lowest_set(search_s);
        alloc_ok_s   = ALLOC_REQ && pick_s[IW];
        alloc_fail_s = ALLOC_REQ && !pick_s[IW];
    end

    // Resolve each free port; a lower-numbered enabled port on the same index wins
    always_comb begin
        logic [IW-1:0] idx_v;
        logic          dup_v;
        idx_v      = {IW{1'b0}};
        dup_v      = 1'b0;
        free_ok_s  = {FREE_PORTS{1'b0}};
        free_err_s = {FREE_PORTS{1'b0}};
        for (int p = 0; p < FREE_PORTS; p++) begin
            idx_v = FREE_IDX[p*IW +: IW];
            dup_v = 1'b0;
            for (int q = 0; q < p; q++) begin
                dup_v = dup_v | (FREE_EN[q] & (FREE_IDX[q*IW +: IW] == idx_v));
            end
            if (FREE_EN[p]) begin
                if (idx_in_range(idx_v) && list_r[idx_v] && !dup_v) begin
                    free_ok_s[p] = 1'b1;
                end else begin
                    free_err_s[p] = 1'b1;
                end
            end else begin
                free_ok_s[p] = 1'b0;
            end
        end
    end

    // Apply frees, claim and grant to the bitmap; they never touch the same bit
    always_comb begin
        list_next_s = list_r;
        free_num_s  = {(CW + 1){1'b0}};
        for (int p = 0; p < FREE_PORTS; p++) begin
            free_num_s = free_num_s + {{CW{1'b0}}, free_ok_s[p]};
            if (free_ok_s[p]) begin
                list_next_s[FREE_IDX[p*IW +: IW]] = 1'b0;
            end else begin
                list_next_s = list_next_s;
            end
        end
        if (claim_ok_s) begin
            list_next_s[CLAIM_IDX] = 1'b1;
        end else begin
            list_next_s = list_next_s;
        end
        if (alloc_ok_s) begin
            list_next_s[pick_s[IW-1:0]] = 1'b1;
        end else begin
            list_next_s = list_next_s;
        end
    end

    // Next free count, kept one bit wider so the intermediate sum cannot wrap
    always_comb begin
        count_next_s = {1'b0, count_r} + free_num_s
                       - {{CW{1'b0}}, claim_ok_s}
                       - {{CW{1'b0}}, alloc_ok_s};
        empty_next_s    = (count_next_s == {(CW + 1){1'b0}});
        all_free_next_s = (count_next_s == FULL_CNT);
        low_next_s      = (32'(count_next_s) <= 32'(LOW_WATER));
    end

    // Register bitmap, counter, flags and the single-cycle response pulses
    always_ff @(posedge CLK) begin
        if (RSTN) begin
            list_r       <= {LIST_SIZE{1'b0}};
            count_r      <= FULL_CNT[CW-1:0];
            alloc_gnt_r  <= 1'b0;
            alloc_fail_r <= 1'b0;
            alloc_idx_r  <= {IW{1'b0}};
            claim_err_r  <= 1'b0;
            free_err_r   <= {FREE_PORTS{1'b0}};
            empty_r      <= 1'b0;
            low_r        <= RESET_LOW;
            all_free_r   <= 1'b1;
        end else begin
            list_r       <= list_next_s;
            count_r      <= count_next_s[CW-1:0];
            alloc_gnt_r  <= alloc_ok_s;
            alloc_fail_r <= alloc_fail_s;
            if (alloc_ok_s) begin
                alloc_idx_r <= pick_s[IW-1:0];
            end else begin
                alloc_idx_r <= alloc_idx_r;
            end
            claim_err_r  <= claim_err_s;
            free_err_r   <= free_err_s;
            empty_r      <= empty_next_s;
            low_r        <= low_next_s;
            all_free_r   <= all_free_next_s;
        end
    end

    assign ALLOC_GNT  = alloc_gnt_r;
    assign ALLOC_FAIL = alloc_fail_r;
    assign ALLOC_IDX  = alloc_idx_r;
    assign CLAIM_ERR  = claim_err_r;
    assign FREE_ERR   = free_err_r;
    assign FREE_COUNT = count_r;
    assign EMPTY      = empty_r;
    assign LOW        = low_r;
    assign ALL_FREE   = all_free_r;

endmodule

// File: tb/tb_bitmap_allocator.sv
// Bench for bitmap_allocator: two instances (32 slots and 20 slots) share one
// stimulus stream. A slot-array reference model predicts each cycle's response,
// pushes it into a per-instance queue, and a monitor pops and compares.
module tb_bitmap_allocator;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       rstn;
    logic       alloc_req;
    logic       claim_en;
    logic [4:0] claim_idx;
    logic [1:0] free_en;
    logic [9:0] free_idx;

    logic       gnt32, fail32, cerr32, empty32, low32, all32;
    logic [4:0] idx32;
    logic [1:0] ferr32;
    logic [5:0] cnt32;
    logic       gnt20, fail20, cerr20, empty20, low20, all20;
    logic [4:0] idx20;
    logic [1:0] ferr20;
    logic [4:0] cnt20;

    bitmap_allocator u_dut32 (
        .CLK(CLK), .RSTN(rstn),
        .ALLOC_REQ(alloc_req), .ALLOC_GNT(gnt32), .ALLOC_FAIL(fail32), .ALLOC_IDX(idx32),
        .CLAIM_EN(claim_en), .CLAIM_IDX(claim_idx), .CLAIM_ERR(cerr32),
        .FREE_EN(free_en), .FREE_IDX(free_idx), .FREE_ERR(ferr32),
        .FREE_COUNT(cnt32), .EMPTY(empty32), .LOW(low32), .ALL_FREE(all32)
    );

    bitmap_allocator #(.LIST_SIZE(20)) u_dut20 (
        .CLK(CLK), .RSTN(rstn),
        .ALLOC_REQ(alloc_req), .ALLOC_GNT(gnt20), .ALLOC_FAIL(fail20), .ALLOC_IDX(idx20),
        .CLAIM_EN(claim_en), .CLAIM_IDX(claim_idx), .CLAIM_ERR(cerr20),
        .FREE_EN(free_en), .FREE_IDX(free_idx), .FREE_ERR(ferr20),
        .FREE_COUNT(cnt20), .EMPTY(empty20), .LOW(low20), .ALL_FREE(all20)
    );

    typedef struct {
        logic       gnt;
        logic       fail;
        logic       idx_chk;
        logic [4:0] idx;
        logic       claim_err;
        logic [1:0] free_err;
        int         count;
        logic       empty;
        logic       low;
        logic       all_free;
    } exp_t;

    exp_t exp_q0[$];
    exp_t exp_q1[$];
    exp_t e0, e1;

    bit m_list[2][32];
    int m_hold[2];

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: slot array per instance, updated from the rules directly
    task automatic model_step(input int k, output exp_t e);
        int         ls;
        bit         pre[32];
        bit         claim_ok;
        bit         dup;
        int         found;
        int         used;
        logic [4:0] fi;
        ls = (k == 0) ? 32 : 20;
        e.gnt = 1'b0; e.fail = 1'b0; e.idx_chk = 1'b0; e.idx = 5'd0;
        e.claim_err = 1'b0; e.free_err = 2'b00; e.count = 0;
        if (rstn) begin
            for (int i = 0; i < 32; i++) m_list[k][i] = 1'b0;
            m_hold[k] = 0;
            e.idx_chk = 1'b1;
            e.count = ls;
        end else begin
            for (int i = 0; i < 32; i++) pre[i] = m_list[k][i];
            claim_ok = claim_en && (int'(claim_idx) < ls) && !pre[claim_idx];
            e.claim_err = claim_en && !claim_ok;
            for (int p = 0; p < 2; p++) begin
                fi  = free_idx[p*5 +: 5];
                dup = 1'b0;
                for (int q = 0; q < p; q++)
                    if (free_en[q] && free_idx[q*5 +: 5] == fi) dup = 1'b1;
                if (free_en[p]) begin
                    if (int'(fi) < ls && pre[fi] && !dup) m_list[k][fi] = 1'b0;
                    else e.free_err[p] = 1'b1;
                end
            end
            if (alloc_req) begin
                found = -1;
                for (int i = 0; i < ls; i++)
                    if (found < 0 && !pre[i] && !(claim_en && int'(claim_idx) == i)) found = i;
                if (found >= 0) begin
                    e.gnt = 1'b1;
                    m_hold[k] = found;
                    m_list[k][found] = 1'b1;
                end else begin
                    e.fail = 1'b1;
                end
                e.idx_chk = 1'b1;
                e.idx = 5'(m_hold[k]);
            end
            if (claim_ok) m_list[k][claim_idx] = 1'b1;
            used = 0;
            for (int i = 0; i < ls; i++) used += int'(m_list[k][i]);
            e.count = ls - used;
        end
        e.empty    = (e.count == 0);
        e.low      = (e.count <= 4);
        e.all_free = (e.count == ls);
    endtask

    // Drive one cycle of stimulus on the falling edge and queue the predictions
    task automatic cyc(input logic r, input logic a, input logic c, input logic [4:0] ci,
                       input logic [1:0] fe, input logic [4:0] f0, input logic [4:0] f1);
        exp_t e;
        @(negedge CLK);
        rstn = r; alloc_req = a; claim_en = c; claim_idx = ci;
        free_en = fe; free_idx = {f1, f0};
        model_step(0, e); exp_q0.push_back(e);
        model_step(1, e); exp_q1.push_back(e);
    endtask

    task automatic cmp(input int k, input string nm, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL t=%0t dut%0d %s got %0d expected %0d", $time, (k == 0) ? 32 : 20, nm, got, want);
        end
    endtask

    task automatic check(input int k, input exp_t e, input logic g, input logic f,
                         input logic [4:0] ix, input logic ce, input logic [1:0] fe,
                         input logic [31:0] cnt, input logic em, input logic lo, input logic al);
        cmp(k, "ALLOC_GNT",  {31'd0, g},  {31'd0, e.gnt});
        cmp(k, "ALLOC_FAIL", {31'd0, f},  {31'd0, e.fail});
        if (e.idx_chk) cmp(k, "ALLOC_IDX", {27'd0, ix}, {27'd0, e.idx});
        cmp(k, "CLAIM_ERR",  {31'd0, ce}, {31'd0, e.claim_err});
        cmp(k, "FREE_ERR",   {30'd0, fe}, {30'd0, e.free_err});
        cmp(k, "FREE_COUNT", cnt, e.count);
        cmp(k, "EMPTY",      {31'd0, em}, {31'd0, e.empty});
        cmp(k, "LOW",        {31'd0, lo}, {31'd0, e.low});
        cmp(k, "ALL_FREE",   {31'd0, al}, {31'd0, e.all_free});
    endtask

    // Monitor: after each rising edge, compare outputs against queued predictions
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q0.size() > 0) begin
                e0 = exp_q0.pop_front();
                check(0, e0, gnt32, fail32, idx32, cerr32, ferr32, 32'(cnt32), empty32, low32, all32);
            end
            if (exp_q1.size() > 0) begin
                e1 = exp_q1.pop_front();
                check(1, e1, gnt20, fail20, idx20, cerr20, ferr20, 32'(cnt20), empty20, low20, all20);
            end
        end
    end

    // Stimulus: directed scenarios followed by a randomized stream
    initial begin
        rstn = 1'b1; alloc_req = 1'b0; claim_en = 1'b0; claim_idx = 5'd0;
        free_en = 2'b00; free_idx = 10'd0;

        // requests during reset are discarded
        cyc(1'b1, 1'b1, 1'b1, 5'd2, 2'b11, 5'd1, 5'd2);
        cyc(1'b1, 1'b0, 1'b0, 5'd0, 2'b00, 5'd0, 5'd0);

        // drain the pool in index order, then one failing request
        repeat (33) cyc(1'b0, 1'b1, 1'b0, 5'd0, 2'b00, 5'd0, 5'd0);
        cyc(1'b0, 1'b0, 1'b0, 5'd0, 2'b00, 5'd0, 5'd0);

        // parallel frees of 5 and 9, then allocation returns the lowest
        cyc(1'b0, 1'b0, 1'b0, 5'd0, 2'b11, 5'd5, 5'd9);
        cyc(1'b0, 1'b1, 1'b0, 5'd0, 2'b00, 5'd0, 5'd0);
        cyc(1'b0, 1'b0, 1'b0, 5'd0, 2'b00, 5'd0, 5'd0);

        // claim 0 with an allocation in the same cycle
        cyc(1'b1, 1'b0, 1'b0, 5'd0, 2'b00, 5'd0, 5'd0);
        cyc(1'b0, 1'b1, 1'b1, 5'd0, 2'b00, 5'd0, 5'd0);
        cyc(1'b0, 1'b0, 1'b1, 5'd3, 2'b00, 5'd0, 5'd0);
        // duplicate free on both ports, then a double free
        cyc(1'b0, 1'b0, 1'b0, 5'd0, 2'b11, 5'd3, 5'd3);
        cyc(1'b0, 1'b0, 1'b0, 5'd0, 2'b01, 5'd3, 5'd0);
        // range boundaries for the 20-slot instance
        cyc(1'b0, 1'b0, 1'b1, 5'd25, 2'b00, 5'd0, 5'd0);
        cyc(1'b0, 1'b0, 1'b1, 5'd19, 2'b00, 5'd0, 5'd0);
        cyc(1'b0, 1'b0, 1'b1, 5'd20, 2'b10, 5'd0, 5'd30);
        // free + claim on the same set bit, then on the same clear bit
        cyc(1'b0, 1'b0, 1'b1, 5'd1, 2'b01, 5'd1, 5'd0);
        cyc(1'b0, 1'b0, 1'b1, 5'd7, 2'b01, 5'd7, 5'd0);
        // allocate down through the low-water mark into exhaustion
        repeat (30) cyc(1'b0, 1'b1, 1'b0, 5'd0, 2'b00, 5'd0, 5'd0);
        // claim that loses the allocator the slot it would otherwise pick
        cyc(1'b0, 1'b0, 1'b0, 5'd0, 2'b11, 5'd2, 5'd4);
        cyc(1'b0, 1'b1, 1'b1, 5'd2, 2'b00, 5'd0, 5'd0);

        // randomized traffic with occasional resets and forced index collisions
        for (int n = 0; n < 900; n++) begin
            logic       r, a, c;
            logic [4:0] ci, f0, f1;
            logic [1:0] fe;
            r  = ($urandom_range(0, 59) == 0);
            a  = 1'($urandom_range(0, 1));
            c  = ($urandom_range(0, 3) == 0);
            ci = 5'($urandom_range(0, 31));
            fe = 2'($urandom_range(0, 3));
            f0 = 5'($urandom_range(0, 31));
            f1 = 5'($urandom_range(0, 31));
            case ($urandom_range(0, 3))
                0:       f1 = f0;
                1:       f0 = ci;
                default: f1 = f1;
            endcase
            cyc(r, a, c, ci, fe, f0, f1);
        end

        // reset mid-operation with requests active drops the pending responses
        repeat (10) cyc(1'b0, 1'b1, 1'b0, 5'd0, 2'b00, 5'd0, 5'd0);
        cyc(1'b1, 1'b1, 1'b1, 5'd4, 2'b11, 5'd2, 5'd3);
        cyc(1'b0, 1'b0, 1'b0, 5'd0, 2'b00, 5'd0, 5'd0);
        cyc(1'b0, 1'b0, 1'b0, 5'd0, 2'b00, 5'd0, 5'd0);

        @(posedge CLK);
        #3;
        cmp(0, "pending_predictions", 32'(exp_q0.size() + exp_q1.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
